// File: rtl/afifo_seq_checker.sv
// ---------------------------------------------------------------------------
// afifo_seq_checker
//
// Self-checking sink for the read side of an AFIFO. It pops first-word-fall-
// through data, checks each word against an incrementing sequence, and
// accumulates a word count and a 64-bit wrapping sum. A run starts on a
// one-cycle start pulse and finishes after NUM_WORDS pops. An optional
// throttle forces idle cycles after every pop.
//
// Ports
//   CLK            read-domain clock
//   RST            asynchronous reset, active-high
//   start          one-cycle pulse that begins a run (ignored while busy)
//   gap[3:0]       idle cycles forced after each pop
//   data_in        AFIFO head word, valid whenever empty=0
//   empty          AFIFO empty flag
//   deq            pop request (combinational)
//   count[31:0]    words popped this run
//   sum[63:0]      wrapping sum of popped words, zero-extended
//   err_count      sequence mismatches this run, saturating
//   first_err_exp  expected value at the first mismatch
//   first_err_got  received value at the first mismatch
//   busy           run in progress
//   done           run complete, results held
//   pass           done with no mismatches
// ---------------------------------------------------------------------------
module afifo_seq_checker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 100000,
  parameter logic [63:0] SEQ_START  = 64'd1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [3:0]            gap,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  empty,
  output logic                  deq,
  output logic [31:0]           count,
  output logic [63:0]           sum,
  output logic [15:0]           err_count,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SEQ_INIT = DATA_WIDTH'(SEQ_START);
  localparam logic [31:0]           LAST_IDX = 32'(NUM_WORDS - 1);

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            gap_cnt_q;
  logic [DATA_WIDTH-1:0] expect_q;
  logic                  pop;
  logic                  clear;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pop request: only while running, data present and the throttle has expired.
  assign pop   = (state_q == RUN) && !empty && (gap_cnt_q == 4'd0);
  assign deq   = pop;
  // A start pulse arriving while a run is active is ignored.
  assign clear = start && (state_q != RUN);

  // Status decoded straight from the state register.
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign pass  = done && (err_count == 16'd0);

  // Stage: next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (pop && (count == LAST_IDX)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage: pop-side accumulate and sequence check
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count         <= 32'd0;
      sum           <= 64'd0;
      err_count     <= 16'd0;
      first_err_exp <= '0;
      first_err_got <= '0;
      expect_q      <= SEQ_INIT;
      gap_cnt_q     <= 4'd0;
    end else if (clear) begin
      count         <= 32'd0;
      sum           <= 64'd0;
      err_count     <= 16'd0;
      first_err_exp <= '0;
      first_err_got <= '0;
      expect_q      <= SEQ_INIT;
      gap_cnt_q     <= 4'd0;
    end else if (pop) begin
      count     <= count + 32'd1;
      sum       <= sum + 64'(data_in);
      gap_cnt_q <= gap;
      if (data_in == expect_q) begin
        expect_q <= expect_q + DATA_WIDTH'(1);
      end else begin
        err_count <= sat_inc16(err_count);
        if (err_count == 16'd0) begin
          first_err_exp <= expect_q;
          first_err_got <= data_in;
        end
        // Resync on the received word so a single drop or duplicate
        // costs exactly one error rather than a cascade.
        expect_q <= data_in + DATA_WIDTH'(1);
      end
    end else if (gap_cnt_q != 4'd0) begin
      gap_cnt_q <= gap_cnt_q - 4'd1;
    end
  end

endmodule
